// File: rtl/spi_flash_rd_ctrl.sv
// spi_flash_rd_ctrl: fabric-side sequencer for the PolarFire system SPI port.
// Accepts one read request (address, byte count), waits for pad ownership,
// runs a mode-0 flash READ on CLK_O/D_O/SS_O and streams the returned bytes
// out over a valid/ready interface.
// Optional feature: define SPI_FAST_READ_EN to issue FAST READ (0x0B) with
// 8 dummy clocks between the address and the data phase.
module spi_flash_rd_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic [23:0]      ADDR,
  input  logic [LEN_W-1:0] LEN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [7:0]       RD_DATA,
  output logic             RD_VALID,
  input  logic             RD_READY,
  input  logic             FAB_SPI_OWNER,
  input  logic             D_I,
  output logic             CLK_O,
  output logic             CLK_OE,
  output logic             D_O,
  output logic             D_OE,
  output logic             SS_O,
  output logic             SS_OE
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD  = 8'h0B;
  localparam int         SR_W = 40;   // command + address + 8 dummy bits
`else
  localparam logic [7:0] CMD  = 8'h03;
  localparam int         SR_W = 32;   // command + address
`endif

  localparam logic [5:0] LAST_OUT = 6'(SR_W - 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_OWN_WAIT  = 3'd1;
  localparam logic [2:0] S_CS_SETUP  = 3'd2;
  localparam logic [2:0] S_SHIFT_OUT = 3'd3;
  localparam logic [2:0] S_SHIFT_IN  = 3'd4;
  localparam logic [2:0] S_CS_HOLD   = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [5:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [7:0]       in_q, in_d;
  logic             full_q, full_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             clk_o_q, clk_o_d;
  logic             clk_oe_q, clk_oe_d;
  logic             d_o_q, d_o_d;
  logic             d_oe_q, d_oe_d;
  logic             ss_o_q, ss_o_d;
  logic             ss_oe_q, ss_oe_d;
  logic             owned;
  logic             stall_rise;

  // Next-state logic: sequencer, SCK divider, shift registers and stream output
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    in_d       = in_q;
    full_d     = full_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    clk_o_d    = clk_o_q;
    clk_oe_d   = clk_oe_q;
    d_o_d      = d_o_q;
    d_oe_d     = d_oe_q;
    ss_o_d     = ss_o_q;
    ss_oe_d    = ss_oe_q;

    owned = (state_q == S_CS_SETUP) || (state_q == S_SHIFT_OUT) ||
            (state_q == S_SHIFT_IN) || (state_q == S_CS_HOLD);
    // A new byte may not start clocking while the previous one is unconsumed
    stall_rise = (bit_q == 6'd0) && rd_valid_q && !RD_READY;

    if (rd_valid_q && RD_READY) rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START && !busy_q) begin
          err_d = 1'b0;
          cnt_d = LEN;
`ifdef SPI_FAST_READ_EN
          sr_d  = {CMD, ADDR, 8'h00};
`else
          sr_d  = {CMD, ADDR};
`endif
          state_d = (LEN == '0) ? S_FINISH : S_OWN_WAIT;
        end
      end

      S_OWN_WAIT: begin
        if (FAB_SPI_OWNER) begin
          state_d  = S_CS_SETUP;
          ss_o_d   = 1'b0;
          ss_oe_d  = 1'b1;
          clk_oe_d = 1'b1;
          d_oe_d   = 1'b1;
          clk_o_d  = 1'b0;
          d_o_d    = sr_q[SR_W-1];
          div_d    = 8'd0;
        end
      end

      // Chip-select setup doubles as the low phase of the first bit
      S_CS_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_SHIFT_OUT;
          clk_o_d = 1'b1;
          div_d   = 8'd0;
          bit_d   = 6'd0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT_OUT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (clk_o_q) begin
            clk_o_d = 1'b0;
            if (bit_q == LAST_OUT) begin
              state_d = S_SHIFT_IN;
              d_oe_d  = 1'b0;
              d_o_d   = 1'b0;
              bit_d   = 6'd0;
            end else begin
              bit_d = bit_q + 6'd1;
              d_o_d = sr_q[SR_W-2];
              sr_d  = {sr_q[SR_W-2:0], 1'b0};
            end
          end else begin
            clk_o_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_SHIFT_IN: begin
        if (div_q == DIV_LAST) begin
          if (clk_o_q) begin
            clk_o_d = 1'b0;
            div_d   = 8'd0;
            bit_d   = (bit_q == 6'd7) ? 6'd0 : bit_q + 6'd1;
          end else if (!stall_rise) begin
            clk_o_d = 1'b1;
            div_d   = 8'd0;
            in_d    = {in_q[6:0], D_I};
            if (bit_q == 6'd7) full_d = 1'b1;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
        // Completed byte is presented one cycle after its last sample
        if (full_q) begin
          rd_data_d  = in_q;
          rd_valid_d = 1'b1;
          full_d     = 1'b0;
          cnt_d      = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_CS_HOLD;
            clk_o_d = 1'b0;
            div_d   = 8'd0;
          end
        end
      end

      S_CS_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d  = S_FINISH;
          ss_o_d   = 1'b1;
          ss_oe_d  = 1'b0;
          clk_oe_d = 1'b0;
          d_oe_d   = 1'b0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_FINISH: begin
        state_d  = S_IDLE;
        ss_o_d   = 1'b1;
        ss_oe_d  = 1'b0;
        clk_oe_d = 1'b0;
        d_oe_d   = 1'b0;
        clk_o_d  = 1'b0;
        d_o_d    = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Losing the pads releases the bus at once and abandons any partial byte
    if (owned && !FAB_SPI_OWNER) begin
      state_d  = S_FINISH;
      err_d    = 1'b1;
      ss_o_d   = 1'b1;
      ss_oe_d  = 1'b0;
      clk_oe_d = 1'b0;
      d_oe_d   = 1'b0;
      clk_o_d  = 1'b0;
      d_o_d    = 1'b0;
      full_d   = 1'b0;
    end

    done_d = (state_q == S_FINISH);
    busy_d = (state_d != S_IDLE) || done_d;
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= S_IDLE;
      div_q      <= 8'd0;
      bit_q      <= 6'd0;
      cnt_q      <= '0;
      sr_q       <= '0;
      in_q       <= 8'd0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
      clk_o_q    <= 1'b0;
      clk_oe_q   <= 1'b0;
      d_o_q      <= 1'b0;
      d_oe_q     <= 1'b0;
      ss_o_q     <= 1'b1;
      ss_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      in_q       <= in_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      clk_o_q    <= clk_o_d;
      clk_oe_q   <= clk_oe_d;
      d_o_q      <= d_o_d;
      d_oe_q     <= d_oe_d;
      ss_o_q     <= ss_o_d;
      ss_oe_q    <= ss_oe_d;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign CLK_O    = clk_o_q;
  assign CLK_OE   = clk_oe_q;
  assign D_O      = d_o_q;
  assign D_OE     = d_oe_q;
  assign SS_O     = ss_o_q;
  assign SS_OE    = ss_oe_q;

endmodule

// File: tb/tb_spi_flash_rd_ctrl.sv
// Directed testbench for spi_flash_rd_ctrl with a mode-0 flash model.
module tb_spi_flash_rd_ctrl;
  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 16;
`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] CMD_EXP = 8'h0B;
  localparam int         DUMMY   = 8;
`else
  localparam logic [7:0] CMD_EXP = 8'h03;
  localparam int         DUMMY   = 0;
`endif
  localparam int SR_W     = 32 + DUMMY;
  localparam int FIRST_RV = 2 + (79 + 2 * DUMMY) * CLK_DIV;
  localparam logic [17:0] RST_VEC = {4'b0000, 8'h00, 6'b000010};

  logic             CLK = 1'b0;
  logic             RESETN = 1'b0;
  logic             START = 1'b0;
  logic [23:0]      ADDR = 24'h0;
  logic [LEN_W-1:0] LEN = '0;
  logic             RD_READY = 1'b0;
  logic             FAB_SPI_OWNER = 1'b1;
  logic             D_I = 1'b0;
  logic BUSY, DONE, ERR, RD_VALID, CLK_O, CLK_OE, D_O, D_OE, SS_O, SS_OE;
  logic [7:0] RD_DATA;

  spi_flash_rd_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .ADDR(ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .RD_READY(RD_READY), .FAB_SPI_OWNER(FAB_SPI_OWNER), .D_I(D_I),
    .CLK_O(CLK_O), .CLK_OE(CLK_OE), .D_O(D_O), .D_OE(D_OE), .SS_O(SS_O), .SS_OE(SS_OE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Flash model: capture MOSI on SCK rise, drive MISO on SCK fall
  int          nbits = 0;
  int          sck_rises = 0;
  int          k;
  logic [63:0] mosi_cap = '0;
  logic [7:0]  fdata [8];

  always @(posedge CLK_O or negedge SS_O) begin
    if (CLK_O === 1'b1) begin
      if (nbits < SR_W) mosi_cap = {mosi_cap[62:0], D_O};
      nbits = nbits + 1;
      sck_rises = sck_rises + 1;
    end else begin
      nbits = 0;
      mosi_cap = '0;
    end
  end

  always @(negedge CLK_O) begin
    if (nbits >= SR_W) begin
      k = nbits - SR_W;
      D_I = fdata[(k / 8) % 8][7 - (k % 8)];
    end
  end

  // Cumulative event bookkeeping
  int         done_cnt = 0;
  int         do_viol = 0;
  int         rv_rise[$];
  logic [7:0] rx[$];
  logic       rv_prev = 1'b0, clk_prev = 1'b0, do_prev = 1'b0;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt = done_cnt + 1;
    if (RD_VALID === 1'b1 && !rv_prev) rv_rise.push_back(cyc);
    if (CLK_O === 1'b1 && clk_prev && D_O !== do_prev) do_viol = do_viol + 1;
    rv_prev  = RD_VALID;
    clk_prev = CLK_O;
    do_prev  = D_O;
  end

  always @(posedge CLK) begin
    if (RESETN && RD_VALID === 1'b1 && RD_READY) rx.push_back(RD_DATA);
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic start_txn(input logic [23:0] a, input logic [LEN_W-1:0] l, output int t0);
    ADDR  = a;
    LEN   = l;
    START = 1'b1;
    step(1);
    START = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i;
    i = 0;
    while (DONE !== 1'b1 && i < bound) begin
      step(1);
      i++;
    end
    chk(tag, 64'(DONE), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int i;
    i = 0;
    while (RD_VALID !== 1'b1 && i < bound) begin
      step(1);
      i++;
    end
    chk(tag, 64'(RD_VALID), 64'd1);
  endtask

  function automatic logic [17:0] outs();
    return {BUSY, DONE, ERR, RD_VALID, RD_DATA, CLK_O, CLK_OE, D_O, D_OE, SS_O, SS_OE};
  endfunction

  function automatic logic [63:0] hdr(input logic [23:0] a);
    return {32'h0, CMD_EXP, a} << DUMMY;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, rx0, d0, r0, rises0;
    logic ok;

    // Reset state
    step(3);
    chk("reset_outputs", 64'(outs()), 64'(RST_VEC));
    RESETN = 1'b1;
    step(2);

    // Basic read, no backpressure
    fdata = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    RD_READY = 1'b1;
    rx0 = rx.size(); d0 = done_cnt; r0 = rv_rise.size();
    start_txn(24'h012345, 16'd4, t0);
    chk("t1_busy", 64'(BUSY), 64'd1);
    step(1);
    chk("t1_cs_low", 64'({SS_O, SS_OE, CLK_OE, D_OE, CLK_O}), 64'b01110);
    step(20);
    ADDR = 24'hFFFFFF; LEN = 16'd7; START = 1'b1;
    step(1);
    START = 1'b0;
    wait_done("t1_done", 1500);
    step(5);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_idle", 64'({BUSY, ERR}), 64'd0);
    chk("t1_mosi", mosi_cap, hdr(24'h012345));
    chk("t1_nbytes", 64'(rx.size() - rx0), 64'd4);
    chk("t1_b0", 64'(rx[rx0]), 64'hA5);
    chk("t1_b1", 64'(rx[rx0+1]), 64'h5A);
    chk("t1_b2", 64'(rx[rx0+2]), 64'hFF);
    chk("t1_b3", 64'(rx[rx0+3]), 64'h00);
    chk("t1_first_valid", 64'((rv_rise.size() > r0) ? rv_rise[r0] - t0 : -1), 64'(FIRST_RV));
    chk("t1_byte_period", 64'((rv_rise.size() > r0 + 1) ? rv_rise[r0+1] - rv_rise[r0] : -1),
        64'(16 * CLK_DIV));
    chk("t1_dout_stable_high", 64'(do_viol), 64'd0);

    // Backpressure on the first byte
    fdata = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h00, 8'h00, 8'h00, 8'h00};
    RD_READY = 1'b0;
    rx0 = rx.size();
    start_txn(24'h00ABCD, 16'd4, t0);
    wait_valid("t2_first_valid", 400);
    chk("t2_first_data", 64'(RD_DATA), 64'h3C);
    step(2);
    rises0 = sck_rises;
    ok = 1'b1;
    repeat (100) begin
      step(1);
      if (CLK_O !== 1'b0) ok = 1'b0;
    end
    chk("t2_sck_low", 64'(ok), 64'd1);
    chk("t2_no_rise", 64'(sck_rises - rises0), 64'd0);
    chk("t2_held_byte", 64'({RD_VALID, RD_DATA}), 64'h13C);
    RD_READY = 1'b1;
    wait_done("t2_done", 1500);
    step(2);
    chk("t2_nbytes", 64'(rx.size() - rx0), 64'd4);
    chk("t2_b0", 64'(rx[rx0]), 64'h3C);
    chk("t2_b1", 64'(rx[rx0+1]), 64'hC3);
    chk("t2_b3", 64'(rx[rx0+3]), 64'h7E);

    // Ownership granted late
    fdata[0] = 8'h96;
    FAB_SPI_OWNER = 1'b0;
    rx0 = rx.size();
    start_txn(24'hABCDEF, 16'd1, t0);
    ok = 1'b1;
    repeat (50) begin
      step(1);
      if ({SS_O, SS_OE, CLK_OE, D_OE, BUSY} !== 5'b10001) ok = 1'b0;
    end
    chk("t3_bus_idle_wait", 64'(ok), 64'd1);
    FAB_SPI_OWNER = 1'b1;
    wait_done("t3_done", 600);
    step(2);
    chk("t3_nbytes", 64'(rx.size() - rx0), 64'd1);
    chk("t3_b0", 64'(rx[rx0]), 64'h96);
    chk("t3_err", 64'(ERR), 64'd0);
    chk("t3_mosi", mosi_cap, hdr(24'hABCDEF));

    // Ownership lost during address bit 10 (overall bit 18)
    r0 = rv_rise.size();
    start_txn(24'h123456, 16'd2, t0);
    step(75);
    chk("t4_pre", 64'({CLK_O, SS_O, SS_OE}), 64'b101);
    chk("t4_bitcount", 64'(nbits), 64'd19);
    FAB_SPI_OWNER = 1'b0;
    step(1);
    chk("t4_released", 64'({SS_O, SS_OE, CLK_OE, D_OE, CLK_O}), 64'b10000);
    chk("t4_err", 64'(ERR), 64'd1);
    step(1);
    chk("t4_done", 64'(DONE), 64'd1);
    step(3);
    chk("t4_no_valid", 64'(rv_rise.size() - r0), 64'd0);
    chk("t4_err_sticky", 64'({ERR, BUSY}), 64'b10);
    FAB_SPI_OWNER = 1'b1;

    // Zero-length request; also clears the error
    rises0 = sck_rises;
    start_txn(24'h000010, 16'd0, t0);
    chk("t5_err_cleared", 64'(ERR), 64'd0);
    chk("t5_done_not_yet", 64'(DONE), 64'd0);
    ok = (SS_O === 1'b1) && (SS_OE === 1'b0);
    step(1);
    chk("t5_done", 64'(DONE), 64'd1);
    if (SS_O !== 1'b1 || SS_OE !== 1'b0) ok = 1'b0;
    step(1);
    chk("t5_busy_clear", 64'(BUSY), 64'd0);
    if (SS_O !== 1'b1 || SS_OE !== 1'b0) ok = 1'b0;
    chk("t5_ss_untouched", 64'(ok), 64'd1);
    chk("t5_no_sck", 64'(sck_rises - rises0), 64'd0);

    // Asynchronous reset in the data phase
    fdata[0] = 8'h11;
    fdata[1] = 8'h22;
    RD_READY = 1'b0;
    start_txn(24'h000100, 16'd2, t0);
    wait_valid("t6_valid", 400);
    chk("t6_busy_before", 64'({BUSY, SS_O}), 64'b10);
    #2;
    RESETN = 1'b0;
    #1;
    chk("t6_async_reset", 64'(outs()), 64'(RST_VEC));
    step(2);
    RESETN = 1'b1;
    step(2);
    chk("t6_after_reset", 64'(outs()), 64'(RST_VEC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
